// File: rtl/uart_pkg.sv
// Shared definitions for the UART boot loader.
//   Command bytes, response bytes, loader FSM state encoding and a helper that
//   sizes the inter-byte timeout counter.
package uart_pkg;

  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] CmdJump  = 8'h4A;
  localparam logic [7:0] RespAck  = 8'h06;
  localparam logic [7:0] RespNak  = 8'h15;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StLen,
    StData,
    StWrite,
    StCsum,
    StJaddr,
    StResp
  } loader_state_e;

  // Bits needed to hold values 0 .. cycles-1.
  function automatic int unsigned timeout_width(input longint unsigned cycles);
    if (cycles < 64'd2) return 1;
    return int'($clog2(cycles));
  endfunction

endpackage

// File: rtl/loader_timeout_timer.sv
// Reloadable down-counter for the loader's inter-byte timeout.
//   clk, reset  : clock, asynchronous active-low reset
//   i_load      : reload to LoadValue (wins over counting)
//   i_en        : count down while high
//   o_expired   : high while enabled, not loading, and the count has reached 0
module loader_timeout_timer #(
  parameter int unsigned       Width     = 16,
  parameter logic [Width-1:0]  LoadValue = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  logic [Width-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LoadValue;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - Width'(1);
    end
  end

  assign o_expired = i_en && !i_load && (r_count == '0);

endmodule

// File: rtl/uart_mem_loader.sv
// UART boot loader: parses WRITE/JUMP packets from the receiver byte stream,
// issues 32-bit little-endian memory writes, answers ACK/NAK and releases the core.
//   clk, reset          : clock, asynchronous active-low reset
//   i_rx_data/valid     : byte stream from UART receiver; o_rx_ready accepts it
//   o_tx_data/valid     : response byte to UART transmitter; i_tx_ready accepts it
//   o_mem_we/addr/wdata : one-cycle memory write (never stalls)
//   o_boot_pc/start     : start PC and one-cycle release pulse after JUMP
//   o_busy              : high whenever a packet or response is in progress
// ADDR_WIDTH must not exceed 32 (address field on the wire is 4 bytes).
module uart_mem_loader
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ    = 125_000_000,
  parameter int unsigned BAUD_RATE     = 115_200,
  parameter int unsigned TIMEOUT_BYTES = 4,
  parameter int unsigned ADDR_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic [ADDR_WIDTH-1:0] o_boot_pc,
  output logic                  o_boot_start,
  output logic                  o_busy
);

  // One byte time is 10 bit times; 64-bit math avoids overflow at high clock rates.
  localparam longint unsigned TimeoutRaw =
      (64'(TIMEOUT_BYTES) * 64'd10 * 64'(CLOCK_FREQ)) / 64'(BAUD_RATE);
  localparam longint unsigned TimeoutCycles = (TimeoutRaw == 64'd0) ? 64'd1 : TimeoutRaw;
  localparam int unsigned TimerWidth = timeout_width(TimeoutCycles);
  // Loading N-1 makes the expiry land N cycles after the last handshake.
  localparam logic [TimerWidth-1:0] TimerLoad = TimerWidth'(TimeoutCycles - 64'd1);

  loader_state_e         r_state, w_state_next;
  logic [31:0]           r_addr, w_addr_next;
  logic [15:0]           r_count, w_count_next;
  logic [31:0]           r_word, w_word_next;
  logic [7:0]            r_sum, w_sum_next;
  logic [1:0]            r_byte_cnt, w_byte_cnt_next;
  logic [7:0]            r_tx_data, w_tx_data_next;
  logic [ADDR_WIDTH-1:0] r_boot_pc, w_boot_pc_next;
  logic                  r_boot_start, w_boot_start_next;
  // Keeps rx_ready low while reset is asserted and for the first cycle after.
  logic                  r_run;

  logic        w_rx_ready;
  logic        w_rx_fire;
  logic        w_timer_en;
  logic        w_expired;
  logic [31:0] w_shift_addr;
  logic [15:0] w_shift_count;

  assign w_rx_fire     = i_rx_valid && w_rx_ready;
  assign w_shift_addr  = {i_rx_data, r_addr[31:8]};
  assign w_shift_count = {i_rx_data, r_count[15:8]};

  loader_timeout_timer #(
    .Width     (TimerWidth),
    .LoadValue (TimerLoad)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_rx_fire),
    .i_en      (w_timer_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_count      <= '0;
      r_word       <= '0;
      r_sum        <= '0;
      r_byte_cnt   <= '0;
      r_tx_data    <= '0;
      r_boot_pc    <= '0;
      r_boot_start <= 1'b0;
      r_run        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_addr       <= w_addr_next;
      r_count      <= w_count_next;
      r_word       <= w_word_next;
      r_sum        <= w_sum_next;
      r_byte_cnt   <= w_byte_cnt_next;
      r_tx_data    <= w_tx_data_next;
      r_boot_pc    <= w_boot_pc_next;
      r_boot_start <= w_boot_start_next;
      r_run        <= 1'b1;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_addr_next       = r_addr;
    w_count_next      = r_count;
    w_word_next       = r_word;
    w_sum_next        = r_sum;
    w_byte_cnt_next   = r_byte_cnt;
    w_tx_data_next    = r_tx_data;
    w_boot_pc_next    = r_boot_pc;
    w_boot_start_next = 1'b0;
    w_rx_ready        = 1'b0;
    w_timer_en        = 1'b0;
    o_mem_we          = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_rx_ready = r_run;
        if (w_rx_fire) begin
          w_byte_cnt_next = 2'd0;
          w_sum_next      = 8'd0;
          if (i_rx_data == CmdWrite) begin
            w_state_next = StAddr;
          end else if (i_rx_data == CmdJump) begin
            w_state_next = StJaddr;
          end
        end
      end

      StAddr: begin
        w_rx_ready = r_run;
        w_timer_en = 1'b1;
        if (w_rx_fire) begin
          w_addr_next     = w_shift_addr;
          w_sum_next      = r_sum + i_rx_data;
          w_byte_cnt_next = r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) w_state_next = StLen;
        end else if (w_expired) begin
          w_tx_data_next = RespNak;
          w_state_next   = StResp;
        end
      end

      StLen: begin
        w_rx_ready = r_run;
        w_timer_en = 1'b1;
        if (w_rx_fire) begin
          w_count_next    = w_shift_count;
          w_sum_next      = r_sum + i_rx_data;
          w_byte_cnt_next = r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd1) begin
            w_byte_cnt_next = 2'd0;
            w_state_next    = (w_shift_count == 16'd0) ? StCsum : StData;
          end
        end else if (w_expired) begin
          w_tx_data_next = RespNak;
          w_state_next   = StResp;
        end
      end

      StData: begin
        w_rx_ready = r_run;
        w_timer_en = 1'b1;
        if (w_rx_fire) begin
          w_word_next     = {i_rx_data, r_word[31:8]};
          w_sum_next      = r_sum + i_rx_data;
          w_byte_cnt_next = r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) w_state_next = StWrite;
        end else if (w_expired) begin
          w_tx_data_next = RespNak;
          w_state_next   = StResp;
        end
      end

      StWrite: begin
        o_mem_we     = 1'b1;
        w_addr_next  = r_addr + 32'd4;
        w_count_next = r_count - 16'd1;
        w_state_next = (r_count == 16'd1) ? StCsum : StData;
      end

      StCsum: begin
        w_rx_ready = r_run;
        w_timer_en = 1'b1;
        if (w_rx_fire) begin
          w_tx_data_next = (i_rx_data == r_sum) ? RespAck : RespNak;
          w_state_next   = StResp;
        end else if (w_expired) begin
          w_tx_data_next = RespNak;
          w_state_next   = StResp;
        end
      end

      StJaddr: begin
        w_rx_ready = r_run;
        w_timer_en = 1'b1;
        if (w_rx_fire) begin
          w_addr_next     = w_shift_addr;
          w_byte_cnt_next = r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            w_boot_pc_next    = {w_shift_addr[ADDR_WIDTH-1:2], 2'b00};
            w_boot_start_next = 1'b1;
            w_tx_data_next    = RespAck;
            w_state_next      = StResp;
          end
        end else if (w_expired) begin
          w_tx_data_next = RespNak;
          w_state_next   = StResp;
        end
      end

      StResp: begin
        if (i_tx_ready) w_state_next = StIdle;
      end

      default: w_state_next = StIdle;
    endcase
  end

  assign o_rx_ready   = w_rx_ready;
  assign o_tx_valid   = (r_state == StResp);
  assign o_tx_data    = r_tx_data;
  assign o_mem_addr   = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign o_mem_wdata  = r_word;
  assign o_boot_pc    = r_boot_pc;
  assign o_boot_start = r_boot_start;
  assign o_busy       = (r_state != StIdle);

endmodule

// File: tb/tb_uart_mem_loader.sv
// Self-checking bench for uart_mem_loader: directed packets plus randomized
// WRITE/JUMP packets checked against a packet-level reference model.
module tb_uart_mem_loader;

  localparam int unsigned ClkFreq  = 1_000_000;
  localparam int unsigned Baud     = 100_000;
  localparam int unsigned ToBytes  = 4;
  localparam int unsigned ToCycles = ToBytes * 10 * ClkFreq / Baud;  // 400

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] o_boot_pc;
  logic        o_boot_start;
  logic        o_busy;

  uart_mem_loader #(
    .CLOCK_FREQ    (ClkFreq),
    .BAUD_RATE     (Baud),
    .TIMEOUT_BYTES (ToBytes),
    .ADDR_WIDTH    (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_rx_ready   (o_rx_ready),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (i_tx_ready),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_boot_pc    (o_boot_pc),
    .o_boot_start (o_boot_start),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [7:0]  tx_q[$];
  logic [31:0] pkt_words[$];
  int          boot_pulses = 0;
  logic [31:0] boot_pc_seen = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Passive monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (o_mem_we) begin
      wq_addr.push_back(o_mem_addr);
      wq_data.push_back(o_mem_wdata);
    end
    if (o_tx_valid && i_tx_ready) tx_q.push_back(o_tx_data);
    if (o_boot_start) begin
      boot_pulses++;
      boot_pc_seen = o_boot_pc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge clk);
    while (!o_rx_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!o_rx_ready) check_eq("rx_accept", {63'b0, o_rx_ready}, 64'd1);
    step();
    i_rx_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    send_byte(b);
    repeat ($urandom_range(0, 2)) step();
  endtask

  task automatic wait_tx(input string tag, input int limit, input logic [7:0] exp);
    int k = 0;
    while (tx_q.size() == 0 && k < limit) begin
      step();
      k++;
    end
    check_eq({tag, "_txcnt"}, tx_q.size(), 1);
    if (tx_q.size() != 0) check_eq(tag, tx_q.pop_front(), exp);
  endtask

  task automatic clear_obs();
    wq_addr.delete();
    wq_data.delete();
    tx_q.delete();
    boot_pulses = 0;
  endtask

  // Builds a WRITE packet from addr and pkt_words, sends it, and checks the
  // resulting memory writes and response against the packet rules.
  task automatic run_write(input string tag, input logic [31:0] addr, input bit corrupt);
    logic [7:0]  pkt[$];
    logic [7:0]  sum;
    logic [15:0] cnt;
    logic [31:0] w;
    logic [31:0] exp_addr;
    cnt = 16'(pkt_words.size());
    pkt.push_back(8'h57);
    for (int i = 0; i < 4; i++) pkt.push_back(addr[8*i +: 8]);
    pkt.push_back(cnt[7:0]);
    pkt.push_back(cnt[15:8]);
    for (int j = 0; j < pkt_words.size(); j++) begin
      w = pkt_words[j];
      for (int i = 0; i < 4; i++) pkt.push_back(w[8*i +: 8]);
    end
    sum = 8'd0;
    for (int i = 1; i < pkt.size(); i++) sum = sum + pkt[i];
    if (corrupt) pkt.push_back(sum + 8'($urandom_range(1, 255)));
    else pkt.push_back(sum);
    clear_obs();
    foreach (pkt[i]) send_gap(pkt[i]);
    wait_tx({tag, "_resp"}, 100, corrupt ? 8'h15 : 8'h06);
    check_eq({tag, "_nwr"}, wq_addr.size(), cnt);
    for (int j = 0; j < pkt_words.size() && j < wq_addr.size(); j++) begin
      exp_addr = (addr & 32'hFFFF_FFFC) + 32'(4 * j);
      check_eq($sformatf("%s_addr%0d", tag, j), wq_addr[j], exp_addr);
      check_eq($sformatf("%s_data%0d", tag, j), wq_data[j], pkt_words[j]);
    end
  endtask

  task automatic run_jump(input string tag, input logic [31:0] addr);
    clear_obs();
    send_gap(8'h4A);
    for (int i = 0; i < 4; i++) send_gap(addr[8*i +: 8]);
    wait_tx({tag, "_resp"}, 100, 8'h06);
    check_eq({tag, "_pulses"}, boot_pulses, 1);
    check_eq({tag, "_pc_at_pulse"}, boot_pc_seen, addr & 32'hFFFF_FFFC);
    check_eq({tag, "_pc"}, o_boot_pc, addr & 32'hFFFF_FFFC);
    check_eq({tag, "_nwr"}, wq_addr.size(), 0);
  endtask

  logic [7:0]  held;
  bit          ok;
  int          k;
  logic [31:0] ra;

  initial begin
    reset      = 1'b0;
    i_rx_data  = '0;
    i_rx_valid = 1'b0;
    i_tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_rx_ready", o_rx_ready, 0);
    check_eq("rst_tx_valid", o_tx_valid, 0);
    check_eq("rst_tx_data", o_tx_data, 0);
    check_eq("rst_mem", {o_mem_we, o_mem_addr, o_mem_wdata}, 0);
    check_eq("rst_boot", {o_boot_start, o_boot_pc}, 0);
    check_eq("rst_busy", o_busy, 0);
    reset = 1'b1;
    repeat (2) step();

    // Reference packet from the documented example.
    pkt_words.delete();
    pkt_words.push_back(32'h0000_0013);
    run_write("wr_ok", 32'h0000_1000, 1'b0);
    run_write("wr_bad", 32'h0000_1000, 1'b1);

    // Address wrap across the top of memory.
    pkt_words.delete();
    for (int i = 0; i < 3; i++) pkt_words.push_back($urandom);
    run_write("wr_wrap", 32'hFFFF_FFFC, 1'b0);

    // Zero-length write and misaligned address.
    pkt_words.delete();
    run_write("wr_zero", 32'h0000_0040, 1'b0);
    pkt_words.push_back(32'hDEAD_BEEF);
    run_write("wr_misal", 32'h0000_0803, 1'b0);

    run_jump("jmp", 32'h0000_2000);

    // Stall after two data bytes: no early response, then NAK on timeout.
    clear_obs();
    send_gap(8'h57);
    for (int i = 0; i < 4; i++) send_gap(8'h00);
    send_gap(8'h01);
    send_gap(8'h00);
    send_gap(8'hAA);
    send_byte(8'hBB);
    repeat (ToCycles * 3 / 4) step();
    check_eq("to_early_tx", tx_q.size(), 0);
    check_eq("to_early_busy", o_busy, 1);
    wait_tx("to_resp", ToCycles, 8'h15);
    repeat (2) step();
    check_eq("to_busy_drop", o_busy, 0);
    check_eq("to_nwr", wq_addr.size(), 0);
    pkt_words.delete();
    pkt_words.push_back(32'h1234_5678);
    pkt_words.push_back(32'h9ABC_DEF0);
    run_write("after_to", 32'h0000_3000, 1'b0);

    // Transmitter back-pressure in the response state.
    i_tx_ready = 1'b0;
    clear_obs();
    send_gap(8'h4A);
    send_gap(8'h00);
    send_gap(8'h30);
    send_gap(8'h00);
    send_byte(8'h00);
    k = 0;
    while (!o_tx_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    held = o_tx_data;
    ok   = o_tx_valid;
    repeat (50) begin
      @(negedge clk);
      if (!o_tx_valid || o_tx_data != held || o_rx_ready) ok = 1'b0;
    end
    check_eq("hold_stable", ok, 1);
    check_eq("hold_data", held, 8'h06);
    step();
    i_tx_ready = 1'b1;
    wait_tx("hold_release", 10, 8'h06);
    check_eq("hold_pc", o_boot_pc, 32'h0000_3000);

    // Asynchronous reset in the middle of the data phase.
    clear_obs();
    send_gap(8'h57);
    send_gap(8'h00);
    send_gap(8'h01);
    send_gap(8'h00);
    send_gap(8'h00);
    send_gap(8'h02);
    send_gap(8'h00);
    send_byte(8'h77);
    #2;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_busy", o_busy, 0);
    check_eq("mid_rst_tx", {o_tx_valid, o_tx_data, o_rx_ready}, 0);
    check_eq("mid_rst_mem", {o_mem_we, o_mem_addr, o_mem_wdata}, 0);
    check_eq("mid_rst_boot", {o_boot_start, o_boot_pc}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) step();
    check_eq("mid_rst_notx", tx_q.size(), 0);
    check_eq("mid_rst_nwr", wq_addr.size(), 0);

    // Unknown command byte is silently dropped.
    clear_obs();
    send_byte(8'hFF);
    repeat (20) step();
    check_eq("garbage_tx", tx_q.size(), 0);
    check_eq("garbage_wr", wq_addr.size(), 0);
    check_eq("garbage_busy", o_busy, 0);

    // Randomized mix of packets.
    for (int n = 0; n < 16; n++) begin
      ra = $urandom;
      if ($urandom_range(0, 9) < 7) begin
        pkt_words.delete();
        repeat ($urandom_range(0, 4)) pkt_words.push_back($urandom);
        run_write($sformatf("rnd%0d_wr", n), ra, ($urandom_range(0, 3) == 0));
      end else begin
        run_jump($sformatf("rnd%0d_jmp", n), ra & 32'hFFFF_FFFC);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
